// File: rtl/updown_bounce_ctrl_if.sv
// updown_bounce_ctrl_if: control/status bundle between bounce controller and counter (UPDOWN_BOUNCE_CNT_EN adds bounce_cnt)
interface updown_bounce_ctrl_if;
  logic       start;
  logic       stop;
  logic [3:0] q;
  logic       cnt_en;
  logic       dir;
  logic       at_top;
  logic       at_bot;
  logic       busy;
  logic       err;
`ifdef UPDOWN_BOUNCE_CNT_EN
  logic [7:0] bounce_cnt;
  modport master (input start, stop, q, output cnt_en, dir, at_top, at_bot, busy, err, bounce_cnt);
  modport slave (output start, stop, q, input cnt_en, dir, at_top, at_bot, busy, err, bounce_cnt);
`else
  modport master (input start, stop, q, output cnt_en, dir, at_top, at_bot, busy, err);
  modport slave (output start, stop, q, input cnt_en, dir, at_top, at_bot, busy, err);
`endif
endinterface

// File: rtl/updown_bounce_ctrl.sv
// updown_bounce_ctrl: steers an up/down counter between LO and HI; UPDOWN_BOUNCE_CNT_EN adds a saturating bounce_cnt
module updown_bounce_ctrl #(
  parameter int LO = 3,
  parameter int HI = 12
) (
  input logic                  clk,
  input logic                  rst_n,
  updown_bounce_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, SEEK, UP, DOWN} state_t;
  localparam logic [4:0] LO5 = 5'(LO);
  localparam logic [4:0] HI5 = 5'(HI);
  state_t     state;
  logic [4:0] q5;
  logic       out_rng;
  logic       go;
  logic       turn_top;
  logic       turn_bot;
  assign q5       = {1'b0, bus.q};
  assign out_rng  = q5 < LO5 || q5 > HI5;
  assign go       = !bus.stop && state == IDLE && bus.start;
  assign turn_top = !bus.stop && !out_rng && state == UP && q5 + 5'd1 == HI5;
  assign turn_bot = !bus.stop && !out_rng && state == DOWN && q5 == LO5 + 5'd1;
  assign bus.busy = state != IDLE;
  // turnarounds are decided one count early so the counter lands exactly on LO/HI
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      bus.cnt_en <= 1'b0;
      bus.dir    <= 1'b0;
      bus.at_top <= 1'b0;
      bus.at_bot <= 1'b0;
      bus.err    <= 1'b0;
    end else begin
      bus.at_top <= turn_top;
      bus.at_bot <= turn_bot;
      if (bus.stop) begin
        state      <= IDLE;
        bus.cnt_en <= 1'b0;
      end else if (go) begin
        state      <= out_rng ? SEEK : q5 == HI5 ? DOWN : UP;
        bus.dir    <= q5 >= HI5;
        bus.cnt_en <= 1'b1;
        bus.err    <= 1'b0;
      end else if (state == SEEK) begin
        if (bus.dir ? q5 == HI5 + 5'd1 : q5 + 5'd1 == LO5) state <= bus.dir ? DOWN : UP;
      end else if (state != IDLE && out_rng) begin
        state      <= IDLE;
        bus.cnt_en <= 1'b0;
        bus.err    <= 1'b1;
      end else if (turn_top) begin
        state   <= DOWN;
        bus.dir <= 1'b1;
      end else if (turn_bot) begin
        state   <= UP;
        bus.dir <= 1'b0;
      end
    end
`ifdef UPDOWN_BOUNCE_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.bounce_cnt <= 8'd0;
    else if (go) bus.bounce_cnt <= 8'd0;
    else if ((turn_top || turn_bot) && bus.bounce_cnt != 8'hff) bus.bounce_cnt <= bus.bounce_cnt + 8'd1;
`endif
endmodule
